// File: rtl/alu_datapath_0to8.sv
// Purpose: execute stage for the 6-bit controller word; 4-entry register file, accumulator, flags, OUT latch, sticky HALT.
// Latency: two cycles from word presented to visible effect (decode register, then execute); one word per cycle.
// Backpressure: none; a word is accepted every cycle, and after HALT every word is forced to NOP until reset.
// Optional: define ALU_DATAPATH_OVF_EN to compute the signed overflow flag; otherwise ovf is tied to 0.
module alu_datapath_0to8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       w,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             halted
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_CMP   = 3'b101;
    localparam logic [2:0] OP_OUT   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [5:0]       w_q, w_d;
    logic [WIDTH-1:0] r_q [4];
    logic [WIDTH-1:0] r_d [4];
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             rv_q, rv_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             halted_q, halted_d;

    logic [2:0]       opcode;
    logic [1:0]       rs;
    logic             imm;
    logic [WIDTH-1:0] operand;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;

    assign opcode    = w_q[5:3];
    assign rs        = w_q[2:1];
    assign imm       = w_q[0];
    assign operand   = imm ? ONE : r_q[rs];
    assign sum       = {1'b0, acc_q} + {1'b0, operand};
    assign diff      = acc_q - operand;
    assign no_borrow = (acc_q >= operand);

    // Decode register: once halted, only NOPs enter the execute stage.
    assign w_d = halted_q ? 6'b000000 : w;

    // Execute the registered word; every state element holds unless its opcode touches it.
    always_comb begin
        r_d      = r_q;
        acc_d    = acc_q;
        result_d = result_q;
        rv_d     = 1'b0;
        zero_d   = zero_q;
        carry_d  = carry_q;
        halted_d = halted_q;
        if (!halted_q) begin
            case (opcode)
                OP_NOP: ;
                OP_LOAD: begin
                    acc_d  = operand;
                    zero_d = (operand == '0);
                end
                OP_STORE: r_d[rs] = acc_q;
                OP_ADD: begin
                    acc_d   = sum[WIDTH-1:0];
                    carry_d = sum[WIDTH];
                    zero_d  = (sum[WIDTH-1:0] == '0);
                end
                OP_SUB: begin
                    acc_d   = diff;
                    carry_d = no_borrow;
                    zero_d  = (diff == '0);
                end
                OP_CMP: begin
                    carry_d = no_borrow;
                    zero_d  = (diff == '0);
                end
                OP_OUT: begin
                    result_d = acc_q;
                    rv_d     = 1'b1;
                end
                OP_HALT: halted_d = 1'b1;
                default: ;
            endcase
        end
    end

    // State registers; reset overrides any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q      <= '0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            w_q      <= w_d;
            for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
            acc_q    <= acc_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
        end
    end

`ifdef ALU_DATAPATH_OVF_EN
    logic ovf_q, ovf_d;
    logic add_ovf, sub_ovf;

    // Sign rule: ADD overflows when like-signed inputs give a different sign; SUB when unlike-signed.
    assign add_ovf = (acc_q[WIDTH-1] == operand[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
    assign sub_ovf = (acc_q[WIDTH-1] != operand[WIDTH-1]) && (diff[WIDTH-1] != acc_q[WIDTH-1]);

    // Overflow flag follows ADD/SUB/CMP only.
    always_comb begin
        ovf_d = ovf_q;
        if (!halted_q) begin
            case (opcode)
                OP_ADD:         ovf_d = add_ovf;
                OP_SUB, OP_CMP: ovf_d = sub_ovf;
                default:        ;
            endcase
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign acc          = acc_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign zero         = zero_q;
    assign carry        = carry_q;
    assign halted       = halted_q;

endmodule

// File: doc/alu_datapath_0to8.md
Name: alu_datapath_0to8

Overview:
- Execution end of the 6-bit control-word interface driven by controller_ALU_0to8.
- Registers the incoming control word `w`, decodes it, and executes it against a 4-entry register file and an accumulator.
- Publishes the accumulator, status flags and an output-latch/valid pulse to the rest of the practiceFSM design.
- A sticky HALT stops execution until reset.

Parameters:
- WIDTH, 8, data width of registers, accumulator and result.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- w  input  6  control word, sampled every posedge. Fields:
  - w[5:3] opcode
  - w[2:1] register select rs
  - w[0] immediate select (operand = 1 when set, else R[rs])
- acc  output  WIDTH  current accumulator value.
- result  output  WIDTH  value latched by the OUT opcode.
- result_valid  output  1  one-cycle pulse when result is updated.
- zero  output  1  flag: last ALU/LOAD result was 0.
- carry  output  1  flag: carry-out of ADD, or no-borrow of SUB/CMP.
- ovf  output  1  signed overflow flag (see Optional Feature).
- halted  output  1  sticky; high after HALT executes.

Behaviour:
- Reset (synchronous): clears w_q (decodes as NOP), R0..R3, acc, result, result_valid, zero, carry, ovf and halted. All outputs read 0 in the cycle after reset is sampled high. Reset asserted mid-operation wins over any opcode in flight.
- Pipeline stage 1 (decode): w_q <= w every cycle, or <= 6'b000000 when halted=1.
- Pipeline stage 2 (execute): acts on w_q. A control word presented before edge N has its effect visible after edge N+1 (2-cycle latency). Throughput is one word per cycle.
- Operand: op = w_q[0] ? 1 : R[rs]. Register reads return the value from before this edge; a STORE followed by a LOAD of the same register in the next word returns the stored value (no hazard, single execute stage).
- Opcodes:
  - 000 NOP: no state change.
  - 001 LOAD: acc <= op; zero updated; carry unchanged.
  - 010 STORE: R[rs] <= acc; flags unchanged. The immediate bit is ignored.
  - 011 ADD: {carry, acc} <= acc + op, as a WIDTH+1-bit sum; zero updated. Wraps modulo 2^WIDTH.
  - 100 SUB: acc <= acc - op; carry <= (acc >= op) unsigned; zero updated. Wraps on borrow.
  - 101 CMP: same flags as SUB; acc unchanged.
  - 110 OUT: result <= acc; result_valid = 1 for exactly the next cycle. Back-to-back OUT words give a continuous high with a fresh result each cycle.
  - 111 HALT: halted <= 1. All further words are forced to NOP until reset. acc, R[], result and flags hold their values; result_valid is 0.
- HALT in w_q together with an OUT already executed in the same cycle: the OUT completes normally, because it is the earlier word.
- Flags change only on the opcodes listed above.

Optional Feature:
- Macro: ALU_DATAPATH_OVF_EN.
- Defined: ovf is updated on ADD/SUB/CMP with two's-complement signed overflow of acc op operand, i.e. sign-in vs sign-out rule. It is cleared by reset and unchanged by other opcodes.
- Undefined: ovf is tied to 0, no overflow logic is synthesised, and all other behaviour is identical.

Test Plan:
- Reset, then hold w=000000 for 5 cycles -> acc=0, result=0, result_valid=0, zero=0, carry=0, halted=0 throughout.
- Counting run: LOAD imm (w=001001, acc=1), then ADD imm (w=011001) 7 times, then OUT (w=110000) -> acc=8; result=8 with a single result_valid pulse 2 cycles after OUT is presented.
- Register path: LOAD imm, STORE R2 (w=010100), ADD R2 (w=011100), then STORE R3 / LOAD R3 -> acc=2, and R3 reads back 2 on the very next word.
- Wrap/flags: drive acc to 255 via 255 ADD-imm steps from 0, then ADD imm -> acc=0, zero=1, carry=1. Then SUB imm -> acc=255, carry=0, zero=0. With ALU_DATAPATH_OVF_EN, ADD from acc=127 -> ovf=1.
- CMP: acc=5, R1=5, CMP R1 (w=101010) -> zero=1, carry=1, acc stays 5.
- HALT: OUT, then HALT (w=111000), then ADD imm x3 -> one result_valid pulse, halted=1, acc unchanged. Then assert reset for 1 cycle -> halted=0 and all outputs return to 0.
